// File: rtl/biu_icu_resp.sv
// BIU responder for ICU miss/fill reads: one outstanding word read, line fills critical-word-first.
// Optional memory-wait timeout is compiled in when BIU_ICU_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module biu_icu_resp #(
  parameter int LINE_WORDS  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icu_req,
  input  logic [31:0] icu_biu_addr,
  input  logic [3:0]  icu_type,
  input  logic [1:0]  icu_size,
  output logic [1:0]  biu_icu_ack,
  output logic [31:0] biu_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvld,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);
  localparam int LW = $clog2(LINE_WORDS);
  localparam int BW = LW + 1;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_DATA = 2'b01;
  localparam logic [1:0] ACK_ERR  = 2'b10;

  typedef enum logic [2:0] {IDLE, CHK, RD, ACK, GAP} state_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  typ;
    logic [1:0]  size;
  } req_t;

  state_t          state;
  req_t            req_q;
  logic [LW-1:0]   word_ptr;
  logic [BW-1:0]   beats;
  logic            abort;
  logic            abort_now;
  logic [31:0]     line_addr;
  logic            unused_addr_lo;

  if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line
    $error("LINE_WORDS must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be at least 1");
  end

  // A flush seen at any point in RD sticks until the outstanding read returns.
  assign abort_now      = abort | ~icu_req;
  assign line_addr      = {req_q.waddr[29:LW], word_ptr, 2'b00};
  assign unused_addr_lo = ^icu_biu_addr[1:0];

`ifdef BIU_ICU_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TW-1:0] tcnt;
  logic          tmo;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_q       <= '0;
      word_ptr    <= '0;
      beats       <= '0;
      abort       <= 1'b0;
      biu_icu_ack <= ACK_NONE;
      biu_data    <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
`ifdef BIU_ICU_TIMEOUT_EN
      tcnt        <= '0;
      tmo         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (icu_req) begin
            req_q <= '{waddr: icu_biu_addr[31:2], typ: icu_type, size: icu_size};
            state <= CHK;
          end
        end
        CHK: begin
          if (req_q.typ != 4'd0) begin
            biu_icu_ack <= ACK_ERR;
            beats       <= '0;
            state       <= ACK;
          end else begin
            beats    <= (req_q.size == 2'b11) ? BW'(LINE_WORDS) : BW'(1);
            word_ptr <= req_q.waddr[LW-1:0];
            abort    <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= {req_q.waddr, 2'b00};
`ifdef BIU_ICU_TIMEOUT_EN
            tcnt     <= '0;
            tmo      <= 1'b0;
`endif
            state    <= RD;
          end
        end
        RD: begin
          abort <= abort_now;
`ifdef BIU_ICU_TIMEOUT_EN
          // mem_req already dropped last cycle; the error beat follows now.
          if (tmo) begin
            beats <= '0;
            if (!abort_now) begin
              biu_icu_ack <= ACK_ERR;
              state       <= ACK;
            end else begin
              state <= GAP;
            end
          end else
`endif
          if (mem_rvld) begin
            mem_req <= 1'b0;
            if (abort_now) begin
              state <= GAP;
            end else begin
              biu_data    <= mem_rdata;
              biu_icu_ack <= mem_err ? ACK_ERR : ACK_DATA;
              beats       <= beats - BW'(1);
              word_ptr    <= word_ptr + LW'(1);
              state       <= ACK;
            end
          end
`ifdef BIU_ICU_TIMEOUT_EN
          else begin
            tcnt <= tcnt + TW'(1);
            if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
              mem_req <= 1'b0;
              tmo     <= 1'b1;
            end
          end
`endif
        end
        ACK: begin
          biu_icu_ack <= ACK_NONE;
          if (biu_icu_ack == ACK_ERR || !icu_req || beats == '0) begin
            state <= GAP;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= line_addr;
            abort    <= 1'b0;
`ifdef BIU_ICU_TIMEOUT_EN
            tcnt     <= '0;
            tmo      <= 1'b0;
`endif
            state    <= RD;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biu_icu_resp.sv
// Bench for biu_icu_resp: requests are planned up front into per-cycle stimulus and expectation
// tables using the protocol timing rules; one negedge process compares the DUT every cycle.
`timescale 1ns/1ps
module tb_biu_icu_resp;
  localparam int CYC = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        icu_req;
  logic [31:0] icu_biu_addr;
  logic [3:0]  icu_type;
  logic [1:0]  icu_size;
  logic [1:0]  biu_icu_ack;
  logic [31:0] biu_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvld;
  logic [31:0] mem_rdata;
  logic        mem_err;

  always #5 clk = ~clk;

  biu_icu_resp #(.LINE_WORDS(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .icu_req(icu_req), .icu_biu_addr(icu_biu_addr),
    .icu_type(icu_type), .icu_size(icu_size), .biu_icu_ack(biu_icu_ack), .biu_data(biu_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  // per-cycle stimulus and expected outputs
  logic        in_req[CYC], in_rvld[CYC], in_err[CYC];
  logic [31:0] in_addr[CYC], in_rdata[CYC];
  logic [3:0]  in_type[CYC];
  logic [1:0]  in_size[CYC];
  logic        exp_mreq[CYC];
  logic [31:0] exp_maddr[CYC], exp_data[CYC];
  logic [1:0]  exp_ack[CYC];
  logic        obs_mreq[CYC];

  int  cyc = 0;
  bit  chk_en = 1'b0;
  int  n_chk = 0, n_fail = 0;
  int  mr_cyc[$];
  logic [31:0] mr_addr[$];
  int  ak_cyc[$];
  logic [1:0]  ak_val[$];
  logic [31:0] ak_dat[$];
  logic mreq_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(biu_icu_ack), 32'(exp_ack[cyc]));
      chk("mem_req", 32'(mem_req), 32'(exp_mreq[cyc]));
      if (exp_mreq[cyc]) chk("mem_addr", mem_addr, exp_maddr[cyc]);
      if (exp_ack[cyc] == 2'b01) chk("biu_data", biu_data, exp_data[cyc]);
      obs_mreq[cyc] <= mem_req;
      if (mem_req && !mreq_prev) begin
        mr_cyc.push_back(cyc);
        mr_addr.push_back(mem_addr);
      end
      if (biu_icu_ack != 2'b00) begin
        ak_cyc.push_back(cyc);
        ak_val.push_back(biu_icu_ack);
        ak_dat.push_back(biu_data);
      end
      mreq_prev <= mem_req;
    end
  end

  function automatic int n_mr(input int a, input int b);
    int n = 0;
    foreach (mr_cyc[i]) if (mr_cyc[i] >= a && mr_cyc[i] < b) n++;
    return n;
  endfunction

  function automatic int first_mr(input int a);
    foreach (mr_cyc[i]) if (mr_cyc[i] >= a) return i;
    return -1;
  endfunction

  function automatic int n_ack(input int a, input int b, input int v);
    int n = 0;
    foreach (ak_cyc[i])
      if (ak_cyc[i] >= a && ak_cyc[i] < b && (v < 0 || int'(ak_val[i]) == v)) n++;
    return n;
  endfunction

  function automatic int ack_at(input int c);
    foreach (ak_cyc[i]) if (ak_cyc[i] == c) return int'(ak_val[i]);
    return -1;
  endfunction

  function automatic logic [31:0] data_at(input int c);
    foreach (ak_cyc[i]) if (ak_cyc[i] == c) return ak_dat[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int n_hi(input int a, input int b);
    int n = 0;
    for (int c = a; c < b; c++) if (obs_mreq[c]) n++;
    return n;
  endfunction

  // Request accepted in IDLE at t0: memory request 2 cycles later; each read returns dly cycles
  // after its mem_req rises (dly<0 = never, timeout build only); ack the cycle after mem_rvld;
  // next beat's mem_req 2 cycles after mem_rvld. nxt = first cycle the block is idle again.
  task automatic plan(input int t0, input logic [31:0] addr, input logic [3:0] typ,
                      input logic [1:0] size, input int dly[4], input int err_b,
                      input int abt_b, input int adrop_b, output int nxt);
    int n, s, r, f, wp, drop;
    logic [31:0] a, d;
    drop = t0 + 1;
    nxt  = t0 + 2;
    if (typ != 4'd0) begin
      f = t0 + 2;
      exp_ack[f] = 2'b10;
      drop = f + 1;
      nxt  = f + 2;
    end else begin
      n = (size == 2'b11) ? 4 : 1;
      s = t0 + 2;
      for (int b = 1; b <= n; b++) begin
        wp = (int'(addr[3:2]) + b - 1) % 4;
        a  = (n == 1) ? {addr[31:2], 2'b00} : {addr[31:4], 2'(wp), 2'b00};
        if (dly[b-1] < 0) begin
          for (int c = s; c < s + 16; c++) begin
            exp_mreq[c]  = 1'b1;
            exp_maddr[c] = a;
          end
          f = s + 17;
          exp_ack[f] = 2'b10;
          in_rvld[f] = 1'b1;
          drop = f + 1;
          nxt  = f + 2;
          break;
        end
        r = s + dly[b-1];
        for (int c = s; c <= r; c++) begin
          exp_mreq[c]  = 1'b1;
          exp_maddr[c] = a;
        end
        d = $urandom;
        in_rvld[r]  = 1'b1;
        in_rdata[r] = d;
        in_err[r]   = (b == err_b);
        if (b == abt_b) begin
          drop = s + 1;
          nxt  = r + 2;
          break;
        end
        f = r + 1;
        exp_ack[f]  = (b == err_b) ? 2'b10 : 2'b01;
        exp_data[f] = d;
        if (b == err_b || b == n) begin
          drop = f + 1;
          nxt  = f + 2;
          break;
        end
        if (b == adrop_b) begin
          drop = f;
          nxt  = f + 2;
          break;
        end
        s = r + 2;
      end
    end
    for (int c = t0; c < drop; c++) begin
      in_req[c]  = 1'b1;
      in_addr[c] = addr;
      in_type[c] = typ;
      in_size[c] = size;
    end
  endtask

  initial begin
    int t, nxt, t1, t2, t3, t4, t5, t5e, tr, last, k, n, mode, nrand;
    int d4[4];
    logic [31:0] t1a[4];
    logic [3:0]  ty;
    logic [1:0]  sz;
`ifdef BIU_ICU_TIMEOUT_EN
    int t6, t6e;
`endif
    t1a = '{32'h108, 32'h10C, 32'h100, 32'h104};
    for (int c = 0; c < CYC; c++) begin
      in_req[c] = 1'b0;  in_rvld[c] = 1'b0;  in_err[c] = 1'($urandom);
      in_addr[c] = $urandom;  in_rdata[c] = $urandom;
      in_type[c] = 4'($urandom);  in_size[c] = 2'($urandom);
      exp_mreq[c] = 1'b0;  exp_maddr[c] = '0;  exp_data[c] = '0;  exp_ack[c] = 2'b00;
      obs_mreq[c] = 1'b0;
    end

    t = 2;
    t1 = t; d4 = '{2, 2, 2, 2};
    plan(t, 32'h0000_0108, 4'd0, 2'b11, d4, 0, 0, 0, nxt); t = nxt + 1;
    t2 = t; d4 = '{1, 1, 1, 1};
    plan(t, 32'h0000_2004, 4'd0, 2'b00, d4, 0, 0, 0, nxt); t = nxt;
    t3 = t;
    plan(t, 32'h0000_3000, 4'd1, 2'b11, d4, 0, 0, 0, nxt); t = nxt + 2;
    t4 = t; d4 = '{1, 3, 2, 2};
    plan(t, 32'h0000_4010, 4'd0, 2'b11, d4, 2, 0, 0, nxt); t = nxt;
    t5 = t; d4 = '{2, 1, 3, 2};
    plan(t, 32'h0000_500C, 4'd0, 2'b11, d4, 0, 3, 0, nxt); t = nxt + 1;
    t5e = t;
`ifdef BIU_ICU_TIMEOUT_EN
    t6 = t; d4 = '{-1, 1, 1, 1};
    plan(t, 32'h0000_6000, 4'd0, 2'b00, d4, 0, 0, 0, nxt); t = nxt;
    t6e = t;
`endif
    nrand = 0;
    while (t < CYC - 200 && nrand < 60) begin
      ty = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
      sz = 2'($urandom);
      n  = (sz == 2'b11) ? 4 : 1;
      foreach (d4[i]) d4[i] = $urandom_range(4, 1);
      mode = $urandom_range(7, 0);
      plan(t, $urandom, ty, sz, d4,
           (mode == 0) ? $urandom_range(n, 1) : 0,
           (mode == 1) ? $urandom_range(n, 1) : 0,
           (mode == 2) ? $urandom_range(n, 1) : 0, nxt);
      t = nxt + $urandom_range(2, 0);
      nrand++;
    end
    tr = t; d4 = '{4, 4, 4, 4};
    plan(t, 32'h0000_7000, 4'd0, 2'b11, d4, 0, 0, 0, nxt);
    last = tr + 3;
    // stray read completions while no read is outstanding must be ignored
    for (int c = 0; c < CYC; c++)
      if (!exp_mreq[c] && !in_rvld[c] && $urandom_range(9, 0) == 0) in_rvld[c] = 1'b1;

    reset = 1'b1; icu_req = 1'b0; icu_biu_addr = '0; icu_type = '0; icu_size = '0;
    mem_rvld = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(biu_icu_ack), 32'd0);
    chk("reset_data", biu_data, 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;

    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      cyc = c;
      chk_en = 1'b1;
      #1;
      icu_req = in_req[c]; icu_biu_addr = in_addr[c]; icu_type = in_type[c]; icu_size = in_size[c];
      mem_rvld = in_rvld[c]; mem_rdata = in_rdata[c]; mem_err = in_err[c];
    end
    #1;
    chk("mid_burst_mem_req", 32'(mem_req), 32'd1);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_ack", 32'(biu_icu_ack), 32'd0);
    chk("async_rst_data", biu_data, 32'd0);
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    icu_req = 1'b0; mem_rvld = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle_req", 32'(mem_req), 32'd0);
    chk("post_rst_idle_ack", 32'(biu_icu_ack), 32'd0);

    // hand-derived expectations for the directed requests
    chk("t1_nreq", 32'(n_mr(t1, t2)), 32'd4);
    k = first_mr(t1);
    for (int i = 0; i < 4; i++)
      if (k >= 0 && k + i < mr_addr.size()) chk("t1_addr_order", mr_addr[k+i], t1a[i]);
    chk("t1_data_acks", 32'(n_ack(t1, t2, 1)), 32'd4);
    chk("t2_nreq", 32'(n_mr(t2, t3)), 32'd1);
    k = first_mr(t2);
    if (k >= 0) chk("t2_addr", mr_addr[k], 32'h0000_2004);
    chk("t2_ack_at_4", 32'(ack_at(t2 + 4)), 32'd1);
    chk("t2_data", data_at(t2 + 4), in_rdata[t2 + 3]);
    chk("t3_no_mem_req", 32'(n_mr(t3, t4)), 32'd0);
    chk("t3_err_at_2", 32'(ack_at(t3 + 2)), 32'd2);
    chk("t3_one_ack", 32'(n_ack(t3, t4, -1)), 32'd1);
    chk("t4_nreq", 32'(n_mr(t4, t5)), 32'd2);
    chk("t4_data_acks", 32'(n_ack(t4, t5, 1)), 32'd1);
    chk("t4_err_acks", 32'(n_ack(t4, t5, 2)), 32'd1);
    chk("t5_nreq", 32'(n_mr(t5, t5e)), 32'd3);
    chk("t5_acks", 32'(n_ack(t5, t5e, -1)), 32'd2);
`ifdef BIU_ICU_TIMEOUT_EN
    chk("t6_req_cycles", 32'(n_hi(t6, t6e)), 32'd16);
    chk("t6_err_after_drop", 32'(ack_at(t6 + 2 + 17)), 32'd2);
    chk("t6_one_ack", 32'(n_ack(t6, t6e, -1)), 32'd1);
`else
    chk("t1_req_cycles", 32'(n_hi(t1, t2)), 32'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
